// File: rtl/pe_network_interface.sv
// PE-side network endpoint: an out FIFO feeds the router PE input channel with
// even/odd VC timing, and an in FIFO buffers the router PE output channel.
module pe_network_interface #(
  parameter int VC_BIT    = 63,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic [63:0] d_in,
  output logic [63:0] d_out,
  input  logic        nicEn,
  input  logic        nicWrEn,
  input  logic        net_polarity,
  output logic        net_so,
  input  logic        net_ro,
  output logic [63:0] net_do,
  input  logic        net_si,
  output logic        net_ri,
  input  logic [63:0] net_di
);

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam logic [IN_AW:0]  IN_MAX  = (IN_AW + 1)'(IN_DEPTH);
  localparam logic [OUT_AW:0] OUT_MAX = (OUT_AW + 1)'(OUT_DEPTH);

  logic [63:0]       in_mem [IN_DEPTH];
  logic [IN_AW-1:0]  in_rd, in_wr;
  logic [IN_AW:0]    in_cnt;
  logic [63:0]       out_mem [OUT_DEPTH];
  logic [OUT_AW-1:0] out_rd, out_wr;
  logic [OUT_AW:0]   out_cnt;
  logic [15:0]       drop_cnt;

  logic in_full, in_nonempty, out_full, out_nonempty;
  logic rd_access, wr_access;
  logic in_push, in_pop, out_push, out_pop, drop_write;
  logic [7:0]  in_cnt8, out_cnt8;
  logic [63:0] out_head;

  assign in_full      = (in_cnt == IN_MAX);
  assign in_nonempty  = (in_cnt != '0);
  assign out_full     = (out_cnt == OUT_MAX);
  assign out_nonempty = (out_cnt != '0);
  assign in_cnt8      = 8'(in_cnt);
  assign out_cnt8     = 8'(out_cnt);

  assign rd_access  = nicEn & ~nicWrEn;
  assign wr_access  = nicEn & nicWrEn;

  // All full/empty decisions use pre-edge state, so same-edge push/pop never interact.
  assign in_push    = net_si & net_ri;
  assign in_pop     = rd_access & (addr == 2'b00) & in_nonempty;
  assign out_push   = wr_access & (addr == 2'b10) & ~out_full;
  assign drop_write = wr_access & (addr == 2'b10) & out_full;
  assign out_pop    = net_so;

  assign out_head = out_mem[out_rd];
  assign net_do   = out_head;
  assign net_ri   = ~in_full;
  assign net_so   = out_nonempty & net_ro & (out_head[VC_BIT] == net_polarity);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_rd  <= '0;
      in_wr  <= '0;
      in_cnt <= '0;
      for (int i = 0; i < IN_DEPTH; i++) in_mem[i] <= '0;
    end else begin
      if (in_push) begin
        in_mem[in_wr] <= net_di;
        in_wr         <= in_wr + 1'b1;
      end
      if (in_pop) in_rd <= in_rd + 1'b1;
      case ({in_push, in_pop})
        2'b10:   in_cnt <= in_cnt + 1'b1;
        2'b01:   in_cnt <= in_cnt - 1'b1;
        default: in_cnt <= in_cnt;
      endcase
    end
  end

  // Memory is cleared on reset so net_do reads as zero until the first write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_rd  <= '0;
      out_wr  <= '0;
      out_cnt <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) out_mem[i] <= '0;
    end else begin
      if (out_push) begin
        out_mem[out_wr] <= d_in;
        out_wr          <= out_wr + 1'b1;
      end
      if (out_pop) out_rd <= out_rd + 1'b1;
      case ({out_push, out_pop})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop_write && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_out <= '0;
    end else if (rd_access) begin
      case (addr)
        2'b00:   d_out <= in_nonempty ? in_mem[in_rd] : 64'h0;
        2'b01:   d_out <= {32'b0, drop_cnt, in_cnt8, 7'b0, in_nonempty};
        2'b11:   d_out <= {32'b0, drop_cnt, out_cnt8, 7'b0, out_full};
        default: d_out <= 64'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_network_interface.sv
// Self-checking bench for pe_network_interface: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a queue model.
module tb_pe_network_interface;

  localparam int IN_DEPTH  = 4;
  localparam int OUT_DEPTH = 4;
  localparam int VC_BIT    = 63;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = '0;
  logic [63:0] d_in = '0;
  logic [63:0] d_out;
  logic        nicEn = 1'b0;
  logic        nicWrEn = 1'b0;
  logic        net_polarity = 1'b0;
  logic        net_so;
  logic        net_ro = 1'b0;
  logic [63:0] net_do;
  logic        net_si = 1'b0;
  logic        net_ri;
  logic [63:0] net_di = '0;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_in[$];
  logic [63:0] m_out[$];
  int          m_drop = 0;
  logic [63:0] m_dout = '0;

  always #5 clk = ~clk;

  pe_network_interface #(
    .VC_BIT(VC_BIT), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_polarity(net_polarity),
    .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_si(net_si), .net_ri(net_ri), .net_di(net_di)
  );

  function automatic logic [63:0] status_word(int drop, int cnt, bit flag);
    return 64'(drop) * 64'd65536 + 64'(cnt) * 64'd256 + 64'(flag);
  endfunction

  function automatic bit exp_so();
    if (m_out.size() == 0) return 1'b0;
    return net_ro && (m_out[0][VC_BIT] == net_polarity);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic wr, input logic [1:0] a,
                               input logic [63:0] d, input logic si, input logic [63:0] di,
                               input logic ro, input logic pol);
    nicEn = en; nicWrEn = wr; addr = a; d_in = d;
    net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: FIFOs as queues, decisions taken from pre-edge state.
  always @(posedge clk or posedge reset) begin : model
    bit so, ri, pop_in, push_out;
    logic [63:0] nd;
    if (reset) begin
      m_in.delete();
      m_out.delete();
      m_drop = 0;
      m_dout = '0;
    end else begin
      so = exp_so();
      ri = (m_in.size() < IN_DEPTH);
      pop_in = 1'b0;
      push_out = 1'b0;
      nd = m_dout;
      if (nicEn && !nicWrEn) begin
        case (addr)
          2'd0: if (m_in.size() > 0) begin nd = m_in[0]; pop_in = 1'b1; end else nd = '0;
          2'd1: nd = status_word(m_drop, m_in.size(), m_in.size() > 0);
          2'd2: nd = '0;
          default: nd = status_word(m_drop, m_out.size(), m_out.size() == OUT_DEPTH);
        endcase
      end
      if (nicEn && nicWrEn && addr == 2'd2) begin
        if (m_out.size() < OUT_DEPTH) push_out = 1'b1;
        else if (m_drop < 65535) m_drop++;
      end
      if (so) void'(m_out.pop_front());
      if (push_out) m_out.push_back(d_in);
      if (pop_in) void'(m_in.pop_front());
      if (net_si && ri) m_in.push_back(net_di);
      m_dout = nd;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("model_net_ri", net_ri, (m_in.size() < IN_DEPTH));
      checkOutput("model_net_so", net_so, exp_so());
      checkOutput("model_d_out", d_out, m_dout);
      if (m_out.size() > 0) checkOutput("model_net_do", net_do, m_out[0]);
    end
  end

  initial begin
    #2;
    checkOutput("rst_net_ri", net_ri, 1'b1);
    checkOutput("rst_net_so", net_so, 1'b0);
    checkOutput("rst_d_out", d_out, 64'h0);
    checkOutput("rst_net_do", net_do, 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    applyStimulus(1, 0, 2'b01, 0, 0, 0, 0, 0); tick();
    checkOutput("rd_in_status", d_out, 64'h0);
    applyStimulus(1, 0, 2'b11, 0, 0, 0, 0, 0); tick();
    checkOutput("rd_out_status", d_out, 64'h0);

    // Single VC0 packet only goes out on an even cycle.
    applyStimulus(1, 1, 2'b10, 64'hAA, 0, 0, 0, 1); tick();
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 1, 1); #1;
    checkOutput("vc0_odd_so", net_so, 1'b0);
    tick();
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 1, 0); #1;
    checkOutput("vc0_even_so", net_so, 1'b1);
    checkOutput("vc0_even_do", net_do, 64'hAA);
    tick();
    applyStimulus(1, 0, 2'b11, 0, 0, 0, 0, 0); tick();
    checkOutput("after_send_status", d_out, 64'h0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 2'b00, 0, 1, 64'h100 + 64'(i), 0, 0); tick();
    end
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0); #1;
    checkOutput("in_full_ri", net_ri, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 2'b00, 0, 0, 0, 0, 0); tick();
      checkOutput("in_read_data", d_out, 64'h100 + 64'(i));
      if (i == 0) checkOutput("in_ri_after_read", net_ri, 1'b1);
    end

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, 2'b10, 64'h200 + 64'(i), 0, 0, 0, 0); tick();
    end
    applyStimulus(1, 0, 2'b11, 0, 0, 0, 0, 0); tick();
    checkOutput("out_full_status", d_out, 64'h0000_0000_0002_0401);
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("drain_so", net_so, 1'b1);
      checkOutput("drain_do", net_do, 64'h200 + 64'(i));
      tick();
    end

    applyStimulus(1, 1, 2'b10, 64'h8000_0000_0000_0001, 0, 0, 0, 0); tick();
    applyStimulus(1, 1, 2'b10, 64'h2, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 1, 0); #1;
    checkOutput("hol_even_so", net_so, 1'b0);
    tick();
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 1, 1); #1;
    checkOutput("hol_odd_so", net_so, 1'b1);
    checkOutput("hol_odd_do", net_do, 64'h8000_0000_0000_0001);
    tick();
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 1, 0); #1;
    checkOutput("hol_next_so", net_so, 1'b1);
    checkOutput("hol_next_do", net_do, 64'h2);
    tick();
    #1 checkOutput("hol_empty_so", net_so, 1'b0);

    // Reset in the middle of an active send.
    applyStimulus(1, 1, 2'b10, 64'h300, 0, 0, 0, 0); tick();
    applyStimulus(1, 0, 2'b11, 0, 0, 0, 0, 0); tick();
    checkOutput("pre_rst_status", d_out, 64'h0000_0000_0002_0100);
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 1, 0); #1;
    checkOutput("pre_rst_so", net_so, 1'b1);
    #1 reset = 1'b1;
    #1;
    checkOutput("mid_rst_so", net_so, 1'b0);
    checkOutput("mid_rst_ri", net_ri, 1'b1);
    checkOutput("mid_rst_d_out", d_out, 64'h0);
    checkOutput("mid_rst_do", net_do, 64'h0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 2'b00, 0, 0, 0, 1, 1'(i)); #1;
      checkOutput("post_rst_so", net_so, 1'b0);
      tick();
    end

    // Randomized traffic; each segment shifts the balance between producers and consumers.
    for (int seg = 0; seg < 6; seg++) begin
      int p_en, p_si, p_ro;
      p_en = 30 + 10 * seg;
      p_si = (seg % 2 == 0) ? 70 : 20;
      p_ro = (seg % 3 == 0) ? 20 : 80;
      for (int c = 0; c < 500; c++) begin
        logic en, wr, si, ro, pol;
        logic [1:0] a;
        logic [63:0] d, di;
        en = ($urandom_range(0, 99) < p_en);
        wr = $urandom_range(0, 1) == 1;
        a  = 2'($urandom_range(0, 3));
        if (wr && $urandom_range(0, 3) != 0) a = 2'b10;
        if (!wr && $urandom_range(0, 2) == 0) a = 2'b00;
        d  = {$urandom, $urandom};
        di = {$urandom, $urandom};
        si = ($urandom_range(0, 99) < p_si);
        ro = ($urandom_range(0, 99) < p_ro);
        pol = (seg >= 3) ? 1'($urandom_range(0, 1)) : 1'(c % 2);
        applyStimulus(en, wr, a, d, si, di, ro, pol);
        tick();
      end
    end

    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
